// File: rtl/lcd_ctrl_param.sv
// HD44780 character LCD controller: power-up init, then full-panel refresh
// from an external character source. Everything runs on clk, paced by a tick enable.
module lcd_ctrl_param #(
  parameter int TICK_DIV   = 2500,
  parameter int ROWS       = 2,
  parameter int COLS       = 16,
  parameter int BUS4       = 0,
  parameter int INIT_WAIT  = 40,
  parameter int CLEAR_WAIT = 4,
  parameter int ADDR_W     = 7
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              update,
  input  logic [7:0]        char_data,
  output logic [ADDR_W-1:0] char_addr,
  output logic              busy,
  output logic              done,
  output logic              lcd_rs,
  output logic              lcd_rw,
  output logic              lcd_e,
  output logic [7:0]        lcd_data
);

  if (TICK_DIV < 2 || TICK_DIV > 65535) begin : g_bad_tick
    $error("lcd_ctrl_param: TICK_DIV out of range 2..65535");
  end
  if (ROWS != 1 && ROWS != 2 && ROWS != 4) begin : g_bad_rows
    $error("lcd_ctrl_param: ROWS must be 1, 2 or 4");
  end
  if (COLS < 1 || COLS > 40) begin : g_bad_cols
    $error("lcd_ctrl_param: COLS out of range 1..40");
  end
  if (BUS4 != 0 && BUS4 != 1) begin : g_bad_bus
    $error("lcd_ctrl_param: BUS4 must be 0 or 1");
  end
  if (ADDR_W < 1 || ADDR_W > 16 || ROWS * COLS > (1 << ADDR_W)) begin : g_bad_addr
    $error("lcd_ctrl_param: ROWS*COLS does not fit in ADDR_W");
  end
  if (INIT_WAIT < 0 || INIT_WAIT > 65536 || CLEAR_WAIT < 0 || CLEAR_WAIT > 65536) begin : g_bad_wait
    $error("lcd_ctrl_param: INIT_WAIT/CLEAR_WAIT out of range 0..65536");
  end

  localparam logic [7:0]  FS       = ((BUS4 != 0) ? 8'h20 : 8'h30) | ((ROWS > 1) ? 8'h08 : 8'h00);
  localparam logic [15:0] TICK_LAST = 16'(TICK_DIV - 1);
  localparam logic [15:0] IW_LAST  = (INIT_WAIT > 0) ? 16'(INIT_WAIT - 1) : 16'd0;
  localparam logic [15:0] CW_LAST  = (CLEAR_WAIT > 0) ? 16'(CLEAR_WAIT - 1) : 16'd0;
  localparam logic [1:0]  ROW_LAST = 2'(ROWS - 1);
  localparam logic [5:0]  COL_LAST = 6'(COLS - 1);

  typedef enum logic [2:0] {
    S_POWERUP, S_INIT_NIB, S_INIT_CMD, S_CLR_WAIT, S_IDLE, S_REF_ADDR, S_REF_DATA
  } state_t;

  state_t      st;
  logic [15:0] tcnt, wcnt;
  logic        tick;
  logic [1:0]  phase, idx, row;
  logic [5:0]  col;
  logic        half, pending;
  logic [3:0]  lo_q;
  logic        cur_rs;
  logic [7:0]  cur_byte, base;

  assign tick   = (tcnt == TICK_LAST);
  assign lcd_rw = 1'b0;
  // Rows 2/3 sit right after rows 0/1 in DDRAM, offset by the panel width.
  assign base   = (row[0] ? 8'h40 : 8'h00) + (row[1] ? 8'(COLS) : 8'h00);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) tcnt <= '0;
    else        tcnt <= tick ? '0 : tcnt + 16'd1;
  end

  always_comb begin
    cur_rs   = 1'b0;
    cur_byte = 8'h00;
    case (st)
      S_INIT_NIB: cur_byte = (idx == 2'd3) ? 8'h20 : 8'h30;
      S_INIT_CMD: case (idx)
                    2'd0:    cur_byte = FS;
                    2'd1:    cur_byte = 8'h0C;
                    2'd2:    cur_byte = 8'h01;
                    default: cur_byte = 8'h06;
                  endcase
      S_REF_ADDR: cur_byte = 8'h80 | base;
      S_REF_DATA: begin cur_rs = 1'b1; cur_byte = char_data; end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      st <= S_POWERUP;  wcnt <= '0;  phase <= '0;  idx <= '0;
      row <= '0;  col <= '0;  half <= 1'b0;  lo_q <= '0;  pending <= 1'b0;
      char_addr <= '0;  busy <= 1'b1;  done <= 1'b0;
      lcd_rs <= 1'b0;  lcd_e <= 1'b0;  lcd_data <= 8'h00;
    end else begin
      done <= 1'b0;
      if (update) pending <= 1'b1;
      if (tick) begin
        case (st)
          S_POWERUP: begin
            if (wcnt == IW_LAST) begin
              wcnt <= '0;
              idx  <= '0;
              st   <= (BUS4 != 0) ? S_INIT_NIB : S_INIT_CMD;
            end else wcnt <= wcnt + 16'd1;
          end
          S_CLR_WAIT: begin
            if (wcnt == CW_LAST) st <= S_INIT_CMD;
            else                 wcnt <= wcnt + 16'd1;
          end
          S_IDLE: begin
            if (update || pending) begin
              pending <= 1'b0;
              busy    <= 1'b1;
              row     <= '0;
              col     <= '0;
              st      <= S_REF_ADDR;
            end
          end
          default: begin
            case (phase)
              2'd0: begin
                lcd_rs <= cur_rs;
                if (half) lcd_data <= {lo_q, 4'h0};
                else begin
                  lo_q     <= cur_byte[3:0];
                  lcd_data <= (BUS4 != 0) ? {cur_byte[7:4], 4'h0} : cur_byte;
                end
                phase <= 2'd1;
              end
              2'd1: begin
                lcd_e <= 1'b1;
                phase <= 2'd2;
              end
              default: begin
                lcd_e <= 1'b0;
                phase <= 2'd0;
                // Init nibbles are single writes; every other 4-bit item is two.
                if (BUS4 != 0 && !half && st != S_INIT_NIB) half <= 1'b1;
                else begin
                  half <= 1'b0;
                  case (st)
                    S_INIT_NIB: begin
                      if (idx == 2'd3) begin idx <= '0; st <= S_INIT_CMD; end
                      else idx <= idx + 2'd1;
                    end
                    S_INIT_CMD: begin
                      if (idx == 2'd3) begin
                        st   <= S_IDLE;
                        busy <= 1'b0;
                      end else if (idx == 2'd2 && CLEAR_WAIT > 0) begin
                        idx  <= 2'd3;
                        wcnt <= '0;
                        st   <= S_CLR_WAIT;
                      end else idx <= idx + 2'd1;
                    end
                    S_REF_ADDR: begin
                      col <= '0;
                      st  <= S_REF_DATA;
                    end
                    default: begin
                      if (col == COL_LAST) begin
                        col <= '0;
                        if (row == ROW_LAST) begin
                          done      <= 1'b1;
                          busy      <= 1'b0;
                          char_addr <= '0;
                          st        <= S_IDLE;
                        end else begin
                          row       <= row + 2'd1;
                          char_addr <= char_addr + 1'b1;
                          st        <= S_REF_ADDR;
                        end
                      end else begin
                        col       <= col + 6'd1;
                        char_addr <= char_addr + 1'b1;
                      end
                    end
                  endcase
                end
              end
            endcase
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_lcd_ctrl_param.sv
// Directed bench: three controller builds (2x16 8-bit, 1x8 4-bit, 4x20 8-bit), TICK_DIV=4.
module tb_lcd_ctrl_param;
  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  logic [2:0] upd = '0;
  logic [2:0] busy_v, done_v, e_v, rs_v, rw_v;
  logic [7:0] data_v [3];
  logic [6:0] addr_v [3];
  logic [7:0] cdat_v [3];

  for (genvar i = 0; i < 3; i++) begin : g_src
    assign cdat_v[i] = 8'h41 + {1'b0, addr_v[i]};
  end

  lcd_ctrl_param #(.TICK_DIV(4)) u_a (
    .clk(clk), .reset(reset), .update(upd[0]), .char_data(cdat_v[0]), .char_addr(addr_v[0]),
    .busy(busy_v[0]), .done(done_v[0]), .lcd_rs(rs_v[0]), .lcd_rw(rw_v[0]), .lcd_e(e_v[0]),
    .lcd_data(data_v[0]));
  lcd_ctrl_param #(.TICK_DIV(4), .BUS4(1), .ROWS(1), .COLS(8)) u_b (
    .clk(clk), .reset(reset), .update(upd[1]), .char_data(cdat_v[1]), .char_addr(addr_v[1]),
    .busy(busy_v[1]), .done(done_v[1]), .lcd_rs(rs_v[1]), .lcd_rw(rw_v[1]), .lcd_e(e_v[1]),
    .lcd_data(data_v[1]));
  lcd_ctrl_param #(.TICK_DIV(4), .ROWS(4), .COLS(20)) u_c (
    .clk(clk), .reset(reset), .update(upd[2]), .char_data(cdat_v[2]), .char_addr(addr_v[2]),
    .busy(busy_v[2]), .done(done_v[2]), .lcd_rs(rs_v[2]), .lcd_rw(rw_v[2]), .lcd_e(e_v[2]),
    .lcd_data(data_v[2]));

  int errors = 0, checks = 0;
  int cyc = 0;
  logic [8:0] q0[$], q1[$], q2[$];
  int t0[$];
  int ndone0 = 0, fall0 = -1, amax2 = 0;
  logic [3:0] lo1 = '0;
  logic rw_or = 1'b0;
  logic [2:0] e_prev = '0, busy_prev = '1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [8:0] qget(input logic [8:0] q[$], input int k);
    return (k < q.size()) ? q[k] : 9'h1FF;
  endfunction

  function automatic logic pick(input int i, input int sig);
    case (sig)
      0:       return busy_v[i];
      1:       return done_v[i];
      default: return e_v[i];
    endcase
  endfunction

  task automatic wait_for(input int i, input int sig, input logic lvl, input int budget,
                          input string tag);
    int n = 0;
    logic v;
    v = pick(i, sig);
    while (v !== lvl && n < budget) begin
      @(negedge clk);
      n++;
      v = pick(i, sig);
    end
    chk(tag, {31'd0, v}, {31'd0, lvl});
  endtask

  task automatic pulse(input int i);
    @(negedge clk); upd[i] = 1'b1;
    @(negedge clk); upd[i] = 1'b0;
  endtask

  always @(posedge clk) begin
    if (!reset) cyc = 0;
    else        cyc++;
  end

  always @(negedge clk) begin
    if (reset) begin
      if (e_v[0] && !e_prev[0]) begin q0.push_back({rs_v[0], data_v[0]}); t0.push_back(cyc); end
      if (e_v[1] && !e_prev[1]) q1.push_back({rs_v[1], data_v[1]});
      if (e_v[2] && !e_prev[2]) q2.push_back({rs_v[2], data_v[2]});
      if (done_v[0]) ndone0++;
      if (!busy_v[0] && busy_prev[0] && fall0 < 0) fall0 = cyc;
      if (int'(addr_v[2]) > amax2) amax2 = int'(addr_v[2]);
      lo1 = lo1 | data_v[1][3:0];
      rw_or = rw_or | (|rw_v);
    end
    e_prev = e_v;
    busy_prev = busy_v;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] nib_exp [12];
    logic [7:0] sa_exp [4];
    logic [8:0] e;
    int nsa, ndat;
    nib_exp = '{4'h3, 4'h3, 4'h3, 4'h2, 4'h2, 4'h0, 4'h0, 4'hC, 4'h0, 4'h1, 4'h0, 4'h6};
    sa_exp  = '{8'h80, 8'hC0, 8'h94, 8'hD4};

    // reset state
    repeat (3) @(negedge clk);
    chk("rst_e", {29'd0, e_v}, 32'd0);
    chk("rst_busy", {29'd0, busy_v}, 32'd7);
    chk("rst_done", {29'd0, done_v}, 32'd0);
    chk("rst_rs", {29'd0, rs_v}, 32'd0);
    chk("rst_data", {24'd0, data_v[0]}, 32'd0);
    chk("rst_addr", {25'd0, addr_v[2]}, 32'd0);
    reset = 1'b1;

    // init sequence, 8-bit and 4-bit
    wait_for(0, 0, 1'b0, 600, "init_a_done");
    wait_for(1, 0, 1'b0, 600, "init_b_done");
    wait_for(2, 0, 1'b0, 600, "init_c_done");
    chk("init_a_count", q0.size(), 4);
    chk("init_a_b0", qget(q0, 0), 9'h038);
    chk("init_a_b1", qget(q0, 1), 9'h00C);
    chk("init_a_b2", qget(q0, 2), 9'h001);
    chk("init_a_b3", qget(q0, 3), 9'h006);
    if (t0.size() == 4) begin
      chk("init_a_first_e", t0[0], 168);
      chk("init_a_gap", t0[1] - t0[0], 12);
      chk("init_a_clrwait", t0[3] - t0[2], 28);
    end else chk("init_a_times", t0.size(), 4);
    chk("init_a_busy_fall", fall0, 224);
    chk("init_b_count", q1.size(), 12);
    for (int k = 0; k < 12; k++) begin
      e = qget(q1, k);
      chk($sformatf("init_b_nib%0d", k), {23'd0, e[8], e[7:4]}, {27'd0, nib_exp[k]});
    end
    chk("init_b_lo_zero", lo1, 0);

    // 2x16 refresh
    q0.delete(); ndone0 = 0;
    pulse(0);
    wait_for(0, 1, 1'b1, 800, "ref_a_done");
    chk("ref_a_busy_at_done", busy_v[0], 0);
    chk("ref_a_addr_at_done", addr_v[0], 0);
    @(negedge clk);
    chk("ref_a_done_1clk", done_v[0], 0);
    chk("ref_a_busy_after", busy_v[0], 0);
    chk("ref_a_count", q0.size(), 34);
    chk("ref_a_done_n", ndone0, 1);
    for (int r = 0; r < 2; r++) begin
      chk($sformatf("ref_a_sa%0d", r), qget(q0, r * 17), (r == 0) ? 9'h080 : 9'h0C0);
      for (int c = 0; c < 16; c++)
        chk($sformatf("ref_a_d%0d_%0d", r, c), qget(q0, r * 17 + 1 + c), 9'h100 | (9'h41 + 9'(r * 16 + c)));
    end

    // 4-bit refresh: both nibbles of SETADDR and first char
    q1.delete();
    pulse(1);
    wait_for(1, 1, 1'b1, 800, "ref_b_done");
    chk("ref_b_count", q1.size(), 18);
    chk("ref_b_sa_hi", qget(q1, 0), 9'h080);
    chk("ref_b_sa_lo", qget(q1, 1), 9'h000);
    chk("ref_b_c0_hi", qget(q1, 2), 9'h140);
    chk("ref_b_c0_lo", qget(q1, 3), 9'h110);
    chk("ref_b_c7_lo", qget(q1, 17), 9'h180);
    chk("ref_b_lo_zero", lo1, 0);

    // 4x20 refresh
    q2.delete(); amax2 = 0;
    pulse(2);
    wait_for(2, 1, 1'b1, 1500, "ref_c_done");
    chk("ref_c_addr_at_done", addr_v[2], 0);
    chk("ref_c_addr_max", amax2, 79);
    nsa = 0; ndat = 0;
    foreach (q2[k]) begin
      if (!q2[k][8]) begin
        if (nsa < 4) chk($sformatf("ref_c_sa%0d", nsa), q2[k][7:0], sa_exp[nsa]);
        nsa++;
      end else ndat++;
    end
    chk("ref_c_sa_count", nsa, 4);
    chk("ref_c_data_count", ndat, 80);
    chk("ref_c_last_char", qget(q2, 83), 9'h190);

    // requests during refresh collapse into one extra
    q0.delete(); ndone0 = 0;
    pulse(0);
    wait_for(0, 0, 1'b1, 20, "pend_start");
    repeat (20) @(negedge clk);
    for (int k = 0; k < 3; k++) begin pulse(0); repeat (10) @(negedge clk); end
    wait_for(0, 1, 1'b1, 800, "pend_done1");
    @(negedge clk);
    wait_for(0, 1, 1'b1, 800, "pend_done2");
    repeat (1000) @(negedge clk);
    chk("pend_done_n", ndone0, 2);
    chk("pend_busy", busy_v[0], 0);
    chk("pend_count", q0.size(), 68);

    // reset while lcd_e is high
    pulse(0);
    wait_for(0, 2, 1'b1, 200, "rst_mid_e_high");
    #2 reset = 1'b0;
    #1;
    chk("rst_mid_e", e_v[0], 0);
    chk("rst_mid_busy", busy_v[0], 1);
    chk("rst_mid_addr", addr_v[0], 0);
    @(negedge clk);
    reset = 1'b1;
    q0.delete(); t0.delete(); fall0 = -1;
    wait_for(0, 0, 1'b0, 600, "rerun_done");
    chk("rerun_count", q0.size(), 4);
    chk("rerun_b0", qget(q0, 0), 9'h038);
    chk("rerun_b3", qget(q0, 3), 9'h006);
    chk("rerun_first_e", (t0.size() > 0) ? t0[0] : -1, 168);
    chk("rw_low", rw_or, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
